// File: rtl/mdu_defs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_defs: shared MDU op codes, HI/LO select codes and FSM states     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mdu_defs;

    localparam logic [2:0] MDC_MS     = 3'b000;
    localparam logic [2:0] MDC_MU     = 3'b001;
    localparam logic [2:0] MDC_DS     = 3'b010;
    localparam logic [2:0] MDC_DU     = 3'b011;
    localparam logic [2:0] MDC_MULADD = 3'b100;

    localparam logic [1:0] MDM_HI = 2'b01;
    localparam logic [1:0] MDM_LO = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic mdc_legal(input logic [2:0] op);
        return op <= MDC_MULADD;
    endfunction

    function automatic logic mdc_is_div(input logic [2:0] op);
        return (op == MDC_DS) || (op == MDC_DU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_arith: combinational multiply / divide / multiply-accumulate     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mdu_arith
    import mdu_defs::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_result,
    output logic        o_div0
);

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic [31:0] w_b_safe;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    always_comb begin
        w_sprod  = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
        w_uprod  = {32'd0, i_a} * {32'd0, i_b};
        o_div0   = mdc_is_div(i_op) && (i_b == 32'd0);
        // Zero divisor is replaced so the dividers never see it; the result is discarded anyway.
        w_b_safe = (i_b == 32'd0) ? 32'd1 : i_b;

        if ((i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF)) begin
            w_sq = i_a;
            w_sr = 32'd0;
        end else begin
            w_sq = $signed(i_a) / $signed(w_b_safe);
            w_sr = $signed(i_a) % $signed(w_b_safe);
        end
        w_uq = i_a / w_b_safe;
        w_ur = i_a % w_b_safe;

        case (i_op)
            MDC_MS:     o_result = w_sprod;
            MDC_MU:     o_result = w_uprod;
            MDC_DS:     o_result = {w_sr, w_sq};
            MDC_DU:     o_result = {w_ur, w_uq};
            MDC_MULADD: o_result = {i_hi, i_lo} + w_sprod;
            default:    o_result = {i_hi, i_lo};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_sequencer: fixed-latency MDU sequencer owning HI/LO and stall    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mdu_sequencer
    import mdu_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDCCtrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  MDM_WE,
    input  logic [1:0]  MDM_RE,
    input  logic        D_use,
    output logic        busy,
    output logic [31:0] RD,
    output logic        stall
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0]      w_result;
    logic             w_div0;

    mdu_arith u_arith (
        .i_op     (op_q),
        .i_a      (a_q),
        .i_b      (b_q),
        .i_hi     (hi_q),
        .i_lo     (lo_q),
        .o_result (w_result),
        .o_div0   (w_div0)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                // A start pulse suppresses any same-cycle mthi/mtlo, legal or not.
                if (start) begin
                    if (mdc_legal(MDCCtrl)) begin
                        state_d = ST_RUN;
                        op_d    = MDCCtrl;
                        a_d     = A;
                        b_d     = B;
                        cnt_d   = mdc_is_div(MDCCtrl) ? CNT_W'(DIV_CYCLES)
                                                      : CNT_W'(MULT_CYCLES);
                    end
                end else if (MDM_WE == MDM_HI) begin
                    hi_d = A;
                end else if (MDM_WE == MDM_LO) begin
                    lo_d = A;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (!w_div0) begin
                        {hi_d, lo_d} = w_result;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        busy  = (state_q == ST_RUN);
        stall = D_use & (start | busy);
        case (MDM_RE)
            MDM_HI:  RD = hi_q;
            MDM_LO:  RD = lo_q;
            default: RD = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mdu_sequencer: scoreboard bench for the MDU sequencer             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mdu_sequencer;
    import mdu_defs::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  MDCCtrl = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [1:0]  MDM_WE = 2'd0;
    logic [1:0]  MDM_RE = 2'd0;
    logic        D_use = 1'b0;
    logic        busy;
    logic [31:0] RD;
    logic        stall;

    mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .MDCCtrl (MDCCtrl),
        .A       (A),
        .B       (B),
        .MDM_WE  (MDM_WE),
        .MDM_RE  (MDM_RE),
        .D_use   (D_use),
        .busy    (busy),
        .RD      (RD),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          n;
    logic [31:0] rhi, rlo;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        MDM_RE = MDM_HI;
        #1 hi = RD;
        MDM_RE = MDM_LO;
        #1 lo = RD;
        MDM_RE = 2'b00;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; MDCCtrl = op; A = a; B = b;
        tick();
        start = 1'b0; MDCCtrl = 3'd0; A = 32'd0; B = 32'd0;
    endtask

    // Counts busy cycles; returns in the first non-busy cycle.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 64) begin
            cyc++;
            tick();
        end
    endtask

    task automatic write_hilo(input logic [1:0] sel, input logic [31:0] v);
        MDM_WE = sel; A = v;
        tick();
        MDM_WE = 2'b00; A = 32'd0;
    endtask

    // Pushes the expectation, runs one op to completion and pops the expectation.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
        sb.push_back('{hi: ehi, lo: elo, cycles: ecyc});
        issue(op, a, b);
        wait_done(n);
        read_hilo(rhi, rlo);
        e = sb.pop_front();
    endtask

    task automatic test_reset();
        reset = 1'b0; D_use = 1'b1;
        repeat (3) tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else pass_cnt++;
        read_hilo(rhi, rlo);
        total_cnt++; if (rhi !== 32'd0) $display("FAIL reset_hi got %h want 0", rhi); else pass_cnt++;
        total_cnt++; if (rlo !== 32'd0) $display("FAIL reset_lo got %h want 0", rlo); else pass_cnt++;
        D_use = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        run_op(MDC_MS, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        total_cnt++; if (n !== e.cycles) $display("FAIL ms_busy got %0d want %0d", n, e.cycles); else pass_cnt++;
        total_cnt++; if (rhi !== e.hi) $display("FAIL ms_hi got %h want %h", rhi, e.hi); else pass_cnt++;
        total_cnt++; if (rlo !== e.lo) $display("FAIL ms_lo got %h want %h", rlo, e.lo); else pass_cnt++;
        run_op(MDC_MU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5);
        total_cnt++; if (n !== e.cycles) $display("FAIL mu_busy got %0d want %0d", n, e.cycles); else pass_cnt++;
        total_cnt++; if (rhi !== e.hi) $display("FAIL mu_hi got %h want %h", rhi, e.hi); else pass_cnt++;
        total_cnt++; if (rlo !== e.lo) $display("FAIL mu_lo got %h want %h", rlo, e.lo); else pass_cnt++;
    endtask

    task automatic test_div();
        run_op(MDC_DS, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        total_cnt++; if (n !== e.cycles) $display("FAIL ds_busy got %0d want %0d", n, e.cycles); else pass_cnt++;
        total_cnt++; if (rhi !== e.hi) $display("FAIL ds_hi got %h want %h", rhi, e.hi); else pass_cnt++;
        total_cnt++; if (rlo !== e.lo) $display("FAIL ds_lo got %h want %h", rlo, e.lo); else pass_cnt++;
        run_op(MDC_DU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 10);
        total_cnt++; if (n !== e.cycles) $display("FAIL du_busy got %0d want %0d", n, e.cycles); else pass_cnt++;
        total_cnt++; if (rhi !== e.hi) $display("FAIL du_hi got %h want %h", rhi, e.hi); else pass_cnt++;
        total_cnt++; if (rlo !== e.lo) $display("FAIL du_lo got %h want %h", rlo, e.lo); else pass_cnt++;
    endtask

    task automatic test_div0();
        write_hilo(MDM_HI, 32'h11);
        read_hilo(rhi, rlo);
        total_cnt++; if (rhi !== 32'h11) $display("FAIL mthi got %h want 00000011", rhi); else pass_cnt++;
        write_hilo(MDM_LO, 32'h22);
        read_hilo(rhi, rlo);
        total_cnt++; if (rlo !== 32'h22) $display("FAIL mtlo got %h want 00000022", rlo); else pass_cnt++;
        run_op(MDC_DS, 32'd5, 32'd0, 32'h11, 32'h22, 10);
        total_cnt++; if (n !== e.cycles) $display("FAIL div0_busy got %0d want %0d", n, e.cycles); else pass_cnt++;
        total_cnt++; if (rhi !== e.hi) $display("FAIL div0_hi got %h want %h", rhi, e.hi); else pass_cnt++;
        total_cnt++; if (rlo !== e.lo) $display("FAIL div0_lo got %h want %h", rlo, e.lo); else pass_cnt++;
    endtask

    task automatic test_muladd();
        write_hilo(MDM_HI, 32'd0);
        write_hilo(MDM_LO, 32'hFFFF_FFFF);
        run_op(MDC_MULADD, 32'd1, 32'd1, 32'h1, 32'h0, 5);
        total_cnt++; if (n !== e.cycles) $display("FAIL madd_busy got %0d want %0d", n, e.cycles); else pass_cnt++;
        total_cnt++; if (rhi !== e.hi) $display("FAIL madd_hi got %h want %h", rhi, e.hi); else pass_cnt++;
        total_cnt++; if (rlo !== e.lo) $display("FAIL madd_lo got %h want %h", rlo, e.lo); else pass_cnt++;
    endtask

    task automatic test_illegal();
        write_hilo(MDM_HI, 32'hA5A5_0001);
        start = 1'b1; MDCCtrl = 3'b101; A = 32'd9; B = 32'd9;
        tick();
        start = 1'b0; MDCCtrl = 3'd0; A = 32'd0; B = 32'd0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL illegal_busy got %b want 0", busy); else pass_cnt++;
        read_hilo(rhi, rlo);
        total_cnt++; if (rhi !== 32'hA5A5_0001) $display("FAIL illegal_hi got %h want a5a50001", rhi); else pass_cnt++;
    endtask

    task automatic test_stall();
        D_use = 1'b1;
        sb.push_back('{hi: 32'd0, lo: 32'd42, cycles: 5});
        start = 1'b1; MDCCtrl = MDC_MS; A = 32'd7; B = 32'd6;
        #1;
        total_cnt++; if (stall !== 1'b1) $display("FAIL stall_c0 got %b want 1", stall); else pass_cnt++;
        tick();
        start = 1'b0; MDCCtrl = 3'd0; A = 32'd0; B = 32'd0;
        for (int c = 1; c <= 5; c++) begin
            total_cnt++;
            if (stall !== 1'b1 || busy !== 1'b1)
                $display("FAIL stall_run cycle %0d got stall=%b busy=%b want 1/1", c, stall, busy);
            else pass_cnt++;
            if (c == 2) begin
                start = 1'b1; MDCCtrl = MDC_MU; A = 32'hDEAD; B = 32'd5; MDM_WE = MDM_HI;
            end else begin
                start = 1'b0; MDCCtrl = 3'd0; A = 32'd0; B = 32'd0; MDM_WE = 2'b00;
            end
            tick();
        end
        total_cnt++; if (stall !== 1'b0 || busy !== 1'b0)
            $display("FAIL stall_end got stall=%b busy=%b want 0/0", stall, busy);
        else pass_cnt++;
        D_use = 1'b0;
        read_hilo(rhi, rlo);
        e = sb.pop_front();
        total_cnt++; if (rhi !== e.hi) $display("FAIL stall_hi got %h want %h", rhi, e.hi); else pass_cnt++;
        total_cnt++; if (rlo !== e.lo) $display("FAIL stall_lo got %h want %h", rlo, e.lo); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        sb.push_back('{hi: 32'd0, lo: 32'd20, cycles: 5});
        issue(MDC_MS, 32'd4, 32'd5);
        wait_done(n);
        e = sb.pop_front();
        total_cnt++; if (n !== e.cycles) $display("FAIL b2b_first_busy got %0d want %0d", n, e.cycles); else pass_cnt++;
        run_op(MDC_MU, 32'd3, 32'd4, 32'd0, 32'd12, 5);
        total_cnt++; if (n !== e.cycles) $display("FAIL b2b_second_busy got %0d want %0d", n, e.cycles); else pass_cnt++;
        total_cnt++; if (rlo !== e.lo) $display("FAIL b2b_lo got %h want %h", rlo, e.lo); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic saw_busy;
        issue(MDC_DS, 32'd100, 32'd7);
        tick();
        tick();
        total_cnt++; if (busy !== 1'b1) $display("FAIL rstmid_pre_busy got %b want 1", busy); else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else pass_cnt++;
        read_hilo(rhi, rlo);
        total_cnt++; if (rhi !== 32'd0 || rlo !== 32'd0)
            $display("FAIL rstmid_hilo got %h/%h want 0/0", rhi, rlo);
        else pass_cnt++;
        tick();
        reset = 1'b1;
        saw_busy = 1'b0;
        repeat (12) begin
            tick();
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        total_cnt++; if (saw_busy !== 1'b0) $display("FAIL rstmid_after_busy got 1 want 0"); else pass_cnt++;
        read_hilo(rhi, rlo);
        total_cnt++; if (rhi !== 32'd0 || rlo !== 32'd0)
            $display("FAIL rstmid_nocommit got %h/%h want 0/0", rhi, rlo);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div0();
        test_muladd();
        test_illegal();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_sequencer.md
# mdu_sequencer

Sequencer for the multiply/divide unit in the P6 pipeline. It accepts the `start`/`MDCCtrl` pair from the E-stage decoder and runs a fixed-latency multiply, divide or multiply-accumulate. It owns the architectural HI/LO registers, serves `mfhi`/`mflo` reads and `mthi`/`mtlo` writes, and raises the D-stage stall request while a result is outstanding.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu/madd.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-low.
- `start` input 1: E-stage MDU op issue, one-cycle pulse.
- `MDCCtrl` input 3: op code. 000 ms, 001 mu, 010 ds, 011 du, 100 muladd; others are no-ops.
- `A` input 32: forwarded rs value in E.
- `B` input 32: forwarded rt value in E.
- `MDM_WE` input 2: 01 writes HI, 10 writes LO (mthi/mtlo), data from `A`.
- `MDM_RE` input 2: 01 reads HI, 10 reads LO.
- `D_use` input 1: the D-stage instruction is an MDU instruction (start/MDM_RE/MDM_WE class).
- `busy` output 1: operation in flight.
- `RD` output 32: HI/LO read data, combinational.
- `stall` output 1: `D_use & (start | busy)`.

## Operation
- State machine with two states:
  - IDLE: `start` with a legal code latches `A`, `B` and the op, loads `cnt` with MULT_CYCLES or DIV_CYCLES, and moves to RUN.
  - RUN: `cnt` decrements each cycle. At `cnt == 1` the result commits to HI/LO on that edge and the state returns to IDLE.
- Arithmetic, 64-bit result `{HI,LO}`:
  - ms: `$signed(A)*$signed(B)`.
  - mu: unsigned product.
  - ds: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - du: unsigned quotient and remainder.
  - muladd: `{HI,LO} + $signed(A)*$signed(B)`, mod 2^64, using the HI/LO value at commit time.
- Divide by zero (ds/du with B = 0): HI/LO unchanged, full DIV_CYCLES busy period still runs.
- Illegal `MDCCtrl` with `start`: no state change, `busy` stays 0.
- `MDM_WE` in IDLE: writes `A` to the selected register on the edge. `MDM_WE` during RUN is ignored; the stall makes it unreachable.
- `start` during RUN is ignored and the in-flight op is not disturbed.
- `start` and `MDM_WE` in the same cycle: `start` wins and `MDM_WE` is dropped.
- `RD`: HI if `MDM_RE == 01`, LO if `MDM_RE == 10`, otherwise 0. It always reflects the current architectural HI/LO.
- `reset` low at any time: state IDLE, `cnt` 0, HI = LO = 0, latched operands 0. Any in-flight op is abandoned with no commit.

## Timing
- Reset values: `busy` 0, `stall` 0, `RD` 0.
- Cycle 0: `start` sampled. Cycles 1..N: `busy` = 1. HI/LO are updated on the edge that ends cycle N. Cycle N+1: `busy` = 0 and `RD` returns the new value.
- `stall` is combinational. It is asserted in cycle 0 through cycle N whenever `D_use` is 1.
- A back-to-back `start` is accepted in cycle N+1 at the earliest.
- `mthi`/`mtlo` take effect on the same edge they are sampled.
- `RD` is readable in the following cycle.

## Structure
- Shared package `mdu_defs` holds:
  - MDCCtrl codes `ms`/`mu`/`ds`/`du`/`muladd`;
  - MDM select codes `hi`/`lo`;
  - state encodings.
- The decoder uses the same package.
- One natural sub-module: `mdu_arith`, combinational. Inputs are the latched op, the operands and the current HI/LO; output is the 64-bit result plus a `div0` flag.
- The sequencer keeps the FSM, counter, HI/LO registers and stall logic.

## Test plan
- Multiply: reset, then `start` with ms, A = 0xFFFFFFFE (−2), B = 3.
  - Required: `busy` high exactly 5 cycles.
  - Then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - Same operands with mu: HI = 0x00000002, LO = 0xFFFFFFFA.
- Divide: ds with A = −7, B = 2, then du with A = 0xFFFFFFF9, B = 2.
  - ds after 10 busy cycles: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - du: LO = 0x7FFFFFFC, HI = 1.
- Divide by zero: mthi 0x11, mtlo 0x22, then ds with B = 0.
  - `busy` high 10 cycles.
  - HI/LO stay 0x11/0x22.
- Multiply-accumulate: HI = 0, LO = 0xFFFFFFFF, then muladd with A = 1, B = 1.
  - Required: HI = 1, LO = 0.
- Stall: hold `D_use` = 1 across a mult.
  - `stall` high from the `start` cycle through the last busy cycle, low the next cycle.
  - `start`/`MDM_WE` pulses during RUN leave the result unchanged.
- Reset mid-operation: pull `reset` low in busy cycle 3 of a div.
  - Immediately: `busy` = 0, HI = LO = 0.
  - No commit occurs after `reset` is released.
